// File: rtl/xosera_pkg.sv
// rtl/xosera_pkg.sv - register numbers, arbiter state encoding and byte-select helper
package xv;

    localparam logic [3:0] REG_WR_ADDR = 4'd0;
    localparam logic [3:0] REG_WR_INCR = 4'd1;
    localparam logic [3:0] REG_DATA    = 4'd2;
    localparam logic [3:0] REG_RD_ADDR = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU_WR,
        ST_CPU_RD,
        ST_RD_CAP
    } arb_state_t;

    // Even byte is the high half of the word, odd byte the low half.
    function automatic logic [7:0] byte_of(input logic [15:0] word, input logic odd);
        return odd ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - VRAM arbiter between video fetch and CPU write/read accesses
module vram_arb
    import xv::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    input  logic        pend_wr,
    input  logic        pend_rd,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [15:0] rd_addr,
    output logic        vid_ack,
    output logic        sel,
    output logic        wr,
    output logic [15:0] addr,
    output logic [15:0] data,
    output logic        wr_done,
    output logic        rd_cap
);

    arb_state_t  state;
    arb_state_t  state_n;
    logic        last_vid;
    logic        last_vid_n;
    logic [15:0] addr_n;
    logic [15:0] data_n;
    logic        cpu_pend;

    assign cpu_pend = pend_wr | pend_rd;
    assign wr_done  = (state == ST_CPU_WR);
    assign rd_cap   = (state == ST_RD_CAP);

    // Video wins unless it just had the slot and the CPU is waiting, giving alternation.
    always_comb begin
        state_n    = ST_IDLE;
        last_vid_n = last_vid;
        addr_n     = addr;
        data_n     = data;
        case (state)
            ST_IDLE: begin
                if (vid_req && !(last_vid && cpu_pend)) begin
                    state_n    = ST_VID;
                    last_vid_n = 1'b1;
                    addr_n     = vid_addr;
                end else if (pend_wr) begin
                    state_n    = ST_CPU_WR;
                    last_vid_n = 1'b0;
                    addr_n     = wr_addr;
                    data_n     = wr_data;
                end else if (pend_rd) begin
                    state_n    = ST_CPU_RD;
                    last_vid_n = 1'b0;
                    addr_n     = rd_addr;
                end
            end
            ST_CPU_RD: state_n = ST_RD_CAP;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_vid <= 1'b0;
            vid_ack  <= 1'b0;
            sel      <= 1'b0;
            wr       <= 1'b0;
            addr     <= 16'h0000;
            data     <= 16'h0000;
        end else begin
            state    <= state_n;
            last_vid <= last_vid_n;
            vid_ack  <= (state_n == ST_VID);
            sel      <= (state_n == ST_VID) || (state_n == ST_CPU_WR) || (state_n == ST_CPU_RD);
            wr       <= (state_n == ST_CPU_WR);
            addr     <= addr_n;
            data     <= data_n;
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - byte-wide register file feeding VRAM accesses through vram_arb
// Optional XOSERA_RD_AUTOINC_EN: read capture also advances RD_ADDR by WR_INCR.
module reg_access_ctrl
    import xv::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        write_strobe_i,
    input  logic        read_strobe_i,
    input  logic [3:0]  reg_num_i,
    input  logic        bytesel_i,
    input  logic [7:0]  bytedata_i,
    output logic [7:0]  rd_data_o,
    input  logic        vid_req_i,
    input  logic [15:0] vid_addr_i,
    output logic        vid_ack_o,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [15:0] vram_addr_o,
    output logic [15:0] vram_data_o,
    input  logic [15:0] vram_data_i,
    output logic        busy_o,
    output logic        ovf_o
);

    logic [15:0] wr_addr;
    logic [15:0] wr_incr;
    logic [15:0] data_reg;
    logic [15:0] rd_addr;
    logic [15:0] rd_buf;
    logic [7:0]  holding;
    logic        pend_wr;
    logic        pend_rd;
    logic        pend_wr_n;
    logic        pend_rd_n;
    logic        wr_done;
    logic        rd_cap;
    logic        rd_addr_step;
    logic        commit;
    logic        access_reg;
    logic        accept;
    logic        drop;
    logic [15:0] commit_val;
    logic [7:0]  rd_byte;

    assign commit     = write_strobe_i & bytesel_i;
    assign commit_val = {holding, bytedata_i};
    assign access_reg = (reg_num_i == REG_DATA) || (reg_num_i == REG_RD_ADDR);
    assign accept     = commit & access_reg & ~busy_o;
    assign drop       = commit & access_reg & busy_o;
    assign pend_wr_n  = (accept && reg_num_i == REG_DATA)    || (pend_wr && !wr_done);
    assign pend_rd_n  = (accept && reg_num_i == REG_RD_ADDR) || (pend_rd && !rd_cap);

`ifdef XOSERA_RD_AUTOINC_EN
    assign rd_addr_step = rd_cap;
`else
    assign rd_addr_step = 1'b0;
`endif

    always_comb begin
        rd_byte = 8'h00;
        case (reg_num_i)
            REG_WR_ADDR: rd_byte = byte_of(wr_addr, bytesel_i);
            REG_WR_INCR: rd_byte = byte_of(wr_incr, bytesel_i);
            REG_DATA:    rd_byte = byte_of(data_reg, bytesel_i);
            REG_RD_ADDR: rd_byte = byte_of(rd_buf, bytesel_i);
            default:     rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_addr   <= 16'h0000;
            wr_incr   <= 16'h0000;
            data_reg  <= 16'h0000;
            rd_addr   <= 16'h0000;
            rd_buf    <= 16'h0000;
            holding   <= 8'h00;
            pend_wr   <= 1'b0;
            pend_rd   <= 1'b0;
            busy_o    <= 1'b0;
            ovf_o     <= 1'b0;
            rd_data_o <= 8'h00;
        end else begin
            if (write_strobe_i && !bytesel_i)
                holding <= bytedata_i;
            // An explicit register commit takes precedence over the post-write increment.
            if (commit && reg_num_i == REG_WR_ADDR)
                wr_addr <= commit_val;
            else if (wr_done)
                wr_addr <= wr_addr + wr_incr;
            if (commit && reg_num_i == REG_WR_INCR)
                wr_incr <= commit_val;
            if (accept && reg_num_i == REG_DATA)
                data_reg <= commit_val;
            if (accept && reg_num_i == REG_RD_ADDR)
                rd_addr <= commit_val;
            else if (rd_addr_step)
                rd_addr <= rd_addr + wr_incr;
            if (rd_cap)
                rd_buf <= vram_data_i;
            pend_wr <= pend_wr_n;
            pend_rd <= pend_rd_n;
            busy_o  <= pend_wr_n | pend_rd_n;
            if (drop)
                ovf_o <= 1'b1;
            if (read_strobe_i)
                rd_data_o <= rd_byte;
        end
    end

    vram_arb u_arb (
        .clk      (clk),
        .rst      (reset_i),
        .vid_req  (vid_req_i),
        .vid_addr (vid_addr_i),
        .pend_wr  (pend_wr),
        .pend_rd  (pend_rd),
        .wr_addr  (wr_addr),
        .wr_data  (data_reg),
        .rd_addr  (rd_addr),
        .vid_ack  (vid_ack_o),
        .sel      (vram_sel_o),
        .wr       (vram_wr_o),
        .addr     (vram_addr_o),
        .data     (vram_data_o),
        .wr_done  (wr_done),
        .rd_cap   (rd_cap)
    );

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        write_strobe_i = 1'b0;
    logic        read_strobe_i = 1'b0;
    logic [3:0]  reg_num_i = 4'h0;
    logic        bytesel_i = 1'b0;
    logic [7:0]  bytedata_i = 8'h00;
    logic [7:0]  rd_data_o;
    logic        vid_req_i = 1'b0;
    logic [15:0] vid_addr_i = 16'h0000;
    logic        vid_ack_o;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [15:0] vram_data_i = 16'h0000;
    logic        busy_o;
    logic        ovf_o;

    int          checks = 0;
    int          errors = 0;
    logic        bg_vid = 1'b0;
    logic        vid_force = 1'b0;
    logic [1:0]  sel_log[$];
    logic [31:0] wr_log[$];

    typedef struct {
        logic [3:0]  rnum;
        logic [15:0] val;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;
    vec_t vecs[8];

    reg_access_ctrl dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .write_strobe_i (write_strobe_i),
        .read_strobe_i  (read_strobe_i),
        .reg_num_i      (reg_num_i),
        .bytesel_i      (bytesel_i),
        .bytedata_i     (bytedata_i),
        .rd_data_o      (rd_data_o),
        .vid_req_i      (vid_req_i),
        .vid_addr_i     (vid_addr_i),
        .vid_ack_o      (vid_ack_o),
        .vram_sel_o     (vram_sel_o),
        .vram_wr_o      (vram_wr_o),
        .vram_addr_o    (vram_addr_o),
        .vram_data_o    (vram_data_o),
        .vram_data_i    (vram_data_i),
        .busy_o         (busy_o),
        .ovf_o          (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vram_model(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [3:0] r, input logic [15:0] v);
        write_strobe_i = 1'b1;
        reg_num_i      = r;
        bytesel_i      = 1'b0;
        bytedata_i     = v[15:8];
        @(negedge clk);
        bytesel_i      = 1'b1;
        bytedata_i     = v[7:0];
        @(negedge clk);
        write_strobe_i = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] r, input logic s, output logic [7:0] d);
        read_strobe_i = 1'b1;
        reg_num_i     = r;
        bytesel_i     = s;
        @(negedge clk);
        read_strobe_i = 1'b0;
        d             = rd_data_o;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy_o}, 32'd0);
    endtask

    always @(posedge clk) begin
        if (vram_sel_o && !vram_wr_o)
            vram_data_i <= vram_model(vram_addr_o);
    end

    always @(negedge clk) begin
        if (!reset_i) begin
            if (vid_ack_o) begin
                check("vid_cycle", {30'd0, vram_sel_o, vram_wr_o}, 32'd2);
                check("vid_addr", {16'd0, vram_addr_o}, {16'd0, vid_addr_i});
            end
            if (vram_sel_o)
                sel_log.push_back({vram_wr_o, vid_ack_o});
            if (vram_sel_o && vram_wr_o)
                wr_log.push_back({vram_addr_o, vram_data_o});
        end
        if (bg_vid) begin
            if (!vid_req_i || vid_ack_o) begin
                vid_req_i  = ($urandom_range(0, 2) != 0);
                vid_addr_i = 16'($urandom);
            end
        end else begin
            vid_req_i = vid_force;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  ex;
        logic [15:0] w;
        logic [3:0]  r;
        logic [15:0] v;
        logic        s;
        logic        found;
        logic [15:0] m_wr_addr, m_incr, m_data, m_rd_buf;
        logic [31:0] exp_wr[$];

        vecs[0] = '{4'd1,  16'h0102, 8'h01, 8'h02};
        vecs[1] = '{4'd0,  16'hA55A, 8'hA5, 8'h5A};
        vecs[2] = '{4'd2,  16'h3C4D, 8'h3C, 8'h4D};
        vecs[3] = '{4'd7,  16'hFFFF, 8'h00, 8'h00};
        vecs[4] = '{4'd15, 16'h1234, 8'h00, 8'h00};
        vecs[5] = '{4'd4,  16'h8001, 8'h00, 8'h00};
        vecs[6] = '{4'd1,  16'h0000, 8'h00, 8'h00};
        vecs[7] = '{4'd0,  16'hFF00, 8'hFF, 8'h00};

        repeat (2) @(negedge clk);
        check("rst_rd_data", {24'd0, rd_data_o}, 32'd0);
        check("rst_vid_ack", {31'd0, vid_ack_o}, 32'd0);
        check("rst_sel", {31'd0, vram_sel_o}, 32'd0);
        check("rst_wr", {31'd0, vram_wr_o}, 32'd0);
        check("rst_addr", {16'd0, vram_addr_o}, 32'd0);
        check("rst_data", {16'd0, vram_data_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ovf", {31'd0, ovf_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            reg_read(4'(i / 2), i[0], d);
            check("rst_reg", {24'd0, d}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].rnum, vecs[i].val);
            wait_idle("vec_idle");
            reg_read(vecs[i].rnum, 1'b0, d);
            check("vec_hi", {24'd0, d}, {24'd0, vecs[i].exp_hi});
            reg_read(vecs[i].rnum, 1'b1, d);
            check("vec_lo", {24'd0, d}, {24'd0, vecs[i].exp_lo});
        end

        // Basic write through DATA with auto-increment
        wr_log.delete();
        bus_write(4'd1, 16'h0001);
        bus_write(4'd0, 16'h1200);
        bus_write(4'd2, 16'hABCD);
        check("w_busy_after_commit", {31'd0, busy_o}, 32'd1);
        wait_idle("w_idle");
        check("w_count", wr_log.size(), 32'd1);
        if (wr_log.size() > 0)
            check("w_write", wr_log[0], 32'h1200ABCD);
        reg_read(4'd0, 1'b0, d);
        check("w_addr_hi", {24'd0, d}, 32'h12);
        reg_read(4'd0, 1'b1, d);
        check("w_addr_lo", {24'd0, d}, 32'h01);

        // WR_ADDR wrap
        bus_write(4'd1, 16'h0002);
        bus_write(4'd0, 16'hFFFF);
        bus_write(4'd2, 16'h5555);
        wait_idle("wrap_idle");
        reg_read(4'd0, 1'b0, d);
        check("wrap_hi", {24'd0, d}, 32'h00);
        reg_read(4'd0, 1'b1, d);
        check("wrap_lo", {24'd0, d}, 32'h01);

        // CPU read into buffer
        bus_write(4'd3, 16'h0040);
        wait_idle("rd_idle");
        reg_read(4'd3, 1'b0, d);
        check("rd_even", {24'd0, d}, 32'hBE);
        reg_read(4'd3, 1'b1, d);
        check("rd_odd", {24'd0, d}, 32'hEF);

        // Held video request alternates with a pending CPU write
        sel_log.delete();
        vid_force = 1'b1;
        bus_write(4'd2, 16'h7777);
        for (int i = 0; i < 40 && sel_log.size() < 3; i++)
            @(negedge clk);
        vid_force = 1'b0;
        check("alt_count", {31'd0, sel_log.size() >= 3}, 32'd1);
        if (sel_log.size() >= 3) begin
            check("alt_0_vid", {30'd0, sel_log[0]}, 32'd1);
            check("alt_1_cpu", {30'd0, sel_log[1]}, 32'd2);
            check("alt_2_vid", {30'd0, sel_log[2]}, 32'd1);
        end
        repeat (3) @(negedge clk);
        wait_idle("alt_idle");

        // Second DATA commit while busy is dropped
        wr_log.delete();
        bus_write(4'd2, 16'h1111);
        write_strobe_i = 1'b1;
        reg_num_i      = 4'd2;
        bytesel_i      = 1'b0;
        bytedata_i     = 8'h22;
        @(negedge clk);
        check("ovf_busy_at_commit", {31'd0, busy_o}, 32'd1);
        bytesel_i      = 1'b1;
        bytedata_i     = 8'h22;
        @(negedge clk);
        write_strobe_i = 1'b0;
        wait_idle("ovf_idle");
        repeat (3) @(negedge clk);
        check("ovf_count", wr_log.size(), 32'd1);
        if (wr_log.size() > 0)
            check("ovf_data", {16'd0, wr_log[0][15:0]}, 32'h1111);
        check("ovf_set", {31'd0, ovf_o}, 32'd1);
        reg_read(4'd2, 1'b0, d);
        check("ovf_data_reg", {24'd0, d}, 32'h11);
        repeat (5) @(negedge clk);
        check("ovf_sticky", {31'd0, ovf_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        check("ovf_cleared", {31'd0, ovf_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        // Reset during CPU_RD abandons the read
        bus_write(4'd3, 16'h0077);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (vram_sel_o && !vram_wr_o && !vid_ack_o)
                found = 1'b1;
            else
                @(negedge clk);
        end
        check("abort_found_rd", {31'd0, found}, 32'd1);
        reset_i = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_sel", {31'd0, vram_sel_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        reg_read(4'd3, 1'b0, d);
        check("abort_buf_hi", {24'd0, d}, 32'd0);
        reg_read(4'd3, 1'b1, d);
        check("abort_buf_lo", {24'd0, d}, 32'd0);
        check("abort_busy_after", {31'd0, busy_o}, 32'd0);

        // Randomised register traffic against a reference model with background video
        m_wr_addr = 16'h0000;
        m_incr    = 16'h0000;
        m_data    = 16'h0000;
        m_rd_buf  = 16'h0000;
        wr_log.delete();
        bg_vid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = 4'($urandom_range(0, 5));
            v = 16'($urandom);
            bus_write(r, v);
            case (r)
                4'd0: m_wr_addr = v;
                4'd1: m_incr = v;
                4'd2: begin
                    m_data = v;
                    exp_wr.push_back({m_wr_addr, v});
                    m_wr_addr = m_wr_addr + m_incr;
                end
                4'd3: m_rd_buf = vram_model(v);
                default: ;
            endcase
            if (r == 4'd2 || r == 4'd3)
                wait_idle("rnd_idle");
            r = 4'($urandom_range(0, 5));
            s = 1'($urandom);
            reg_read(r, s, d);
            case (r)
                4'd0: w = m_wr_addr;
                4'd1: w = m_incr;
                4'd2: w = m_data;
                4'd3: w = m_rd_buf;
                default: w = 16'h0000;
            endcase
            ex = s ? w[7:0] : w[15:8];
            check("rnd_read", {24'd0, d}, {24'd0, ex});
        end
        bg_vid = 1'b0;
        repeat (4) @(negedge clk);
        check("rnd_wr_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check("rnd_wr", wr_log[i], exp_wr[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
